data_memory_port: RTL and testbench
===================================

# data_memory_port

Handshaked responder for CPU data loads and stores. It sits between the CPU's load/store datapath (initiator) and a word-organised RAM array held inside the block. It accepts one request at a time and holds it for a configurable number of wait states. It then returns a response that carries the read data (or a write acknowledge) and an error flag.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words in the array; power of two, 4..4096
- LATENCY, 2, wait cycles between request accept and response; 0..15

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_address  in  32  byte address
- req_write_data  in  32  store data
- req_byte_en  in  4  store lane enables, bit i = byte i (only with DMEM_BYTE_ENABLE_EN)
- resp_valid  out  1  response available
- resp_ready  in  1  initiator takes the response
- resp_read_data  out  32  load data; 0 for stores and errors
- resp_error  out  1  request was rejected

## Operation
- States: IDLE, WAIT, RESP. `req_ready = (state == IDLE)`. `resp_valid = (state == RESP)`.
- Accept happens on a rising edge with `req_valid && req_ready`. At that edge the block latches `req_we`, `req_address`, `req_write_data` (and `req_byte_en`).
  - LATENCY = 0: go directly to RESP.
  - Otherwise: load the wait counter with LATENCY-1 and go to WAIT.
- WAIT: decrement each edge. The edge on which the counter reads 0 commits the access and enters RESP.
- Commit (the edge entering RESP):
  - Word index = `address[log2(DEPTH)+1:2]`.
  - Error if `address >= 4*DEPTH` or `address[1:0] != 0`.
  - Store: array written unless error; `resp_read_data` = 0.
  - Load: `resp_read_data` = array word, or 0 on error.
  - `resp_error` registered.
- RESP: `resp_read_data` and `resp_error` are held stable until a `resp_valid && resp_ready` edge, which returns the block to IDLE and clears both to 0.
- One outstanding request at most. No accept is possible in WAIT or RESP; `req_valid` is ignored there.
- Array contents are not reset. Reads of never-written words are undefined (X in simulation).
- Ordering: every load observes all previously committed stores.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, counter 0.
  - Outputs: `req_ready` = 1, `resp_valid` = 0, `resp_read_data` = 0, `resp_error` = 0.
  - A request in WAIT or RESP is dropped. A store not yet committed is never written. Array contents are untouched.
- Accept at edge E0: `resp_valid` rises after edge E0+LATENCY.
- Response consumed at edge E1: `req_ready` is high after E1. The next accept is possible at E1+1.
- Peak throughput: one request per LATENCY+2 cycles.
- `req_ready` depends only on state, never combinationally on `req_valid`.
- `resp_valid`, once high, stays high until consumed. Data does not change while `resp_ready` is low.

## Configuration
- DMEM_BYTE_ENABLE_EN defined:
  - `req_byte_en` port exists, and a store writes only the enabled byte lanes.
  - `byte_en` = 0000 is a legal no-op store with `resp_error` = 0.
  - The alignment check still applies to `address[1:0]`.
- Not defined:
  - No `req_byte_en` port, and every store writes the full word.

## Test plan
- Write then read, LATENCY=2: store 777 to address 8, then load address 8. Load response has `resp_read_data` = 777 and `resp_error` = 0. Each `resp_valid` rises exactly 2 cycles after its accept edge.
- Zero latency, LATENCY=0: stores of 5 to 0x0 and 9 to 0x4, then loads. `resp_valid` is high the cycle after accept, and the loads return 5 and 9. Back-to-back accepts are spaced 2 cycles apart.
- Backpressure: hold `resp_ready` low for 3 cycles after a load of 777. `resp_valid` stays 1, data stays 777, `req_ready` stays 0, and an offered `req_valid` is not accepted.
- Errors, DEPTH=64:
  - Store to 0x100: `resp_error` = 1. A subsequent load of address 0 returns its prior value unchanged.
  - Load from 0x9: `resp_error` = 1, `resp_read_data` = 0.
- Reset mid-operation: accept a store of 0xAAAA to address 12 (prior value 3), then pulse `reset_n` low during WAIT.
  - Outputs return to reset values immediately, asynchronously.
  - A later load of address 12 returns 3.
- With DMEM_BYTE_ENABLE_EN: word 0x11223344 at address 16, then store 0xAABBCCDD with `byte_en` = 0101. A load returns 0x11BB33DD.

Source files
------------

// File: rtl/data_memory_port.sv
// data_memory_port: single-outstanding load/store responder in front of an internal
// word-organised RAM. A request is held for LATENCY wait cycles, then committed, and the
// response is presented until the initiator takes it.
// Optional build macro: DMEM_BYTE_ENABLE_EN adds req_byte_en and per-lane store masking.

module data_memory_port #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
`ifdef DMEM_BYTE_ENABLE_EN
    input  logic [3:0]  req_byte_en,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] AddrLimit = 32'(4 * DEPTH);
    localparam logic [3:0]  CntInit   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0]    be_q;
`endif

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    logic          c_err;
    logic [AW-1:0] c_idx;
    logic          c_wr;

    assign req_ready      = (state_q == StIdle);
    assign resp_valid     = (state_q == StResp);
    assign resp_read_data = rdata_q;
    assign resp_error     = err_q;
    assign accept         = req_valid && req_ready;

    // Select the access to commit: with zero latency it commits straight from the request
    // inputs on the accept edge, otherwise from the latched copy.
    always_comb begin
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
`ifdef DMEM_BYTE_ENABLE_EN
        c_be    = be_q;
`else
        c_be    = 4'hF;
`endif
        if (state_q == StIdle) begin
            commit  = accept && (LATENCY == 0);
            c_we    = req_we;
            c_addr  = req_address;
            c_wdata = req_write_data;
`ifdef DMEM_BYTE_ENABLE_EN
            c_be    = req_byte_en;
`endif
        end else if (state_q == StWait) begin
            commit = (cnt_q == 4'd0);
        end
        c_err = (c_addr >= AddrLimit) || (c_addr[1:0] != 2'b00);
        c_idx = c_addr[AW+1:2];
        // Gate on reset so a request seen while reset is held never reaches the array.
        c_wr  = commit && c_we && !c_err && reset_n;
    end

    // Next-state, wait counter and response register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_we || c_err) ? 32'd0 : mem[c_idx];
        end
    end

    // Control state, counter and response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latch the request fields on accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q    <= 4'd0;
`endif
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_address;
            wdata_q <= req_write_data;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q    <= req_byte_en;
`endif
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (c_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_resp_hold: assert property (@(posedge clock) disable iff (!reset_n)
        resp_valid && !resp_ready |=> resp_valid && $stable(resp_read_data)
                                      && $stable(resp_error));
    a_ready_excl: assert property (@(posedge clock) disable iff (!reset_n)
        !(req_ready && resp_valid));
`endif

endmodule

// File: tb/tb_data_memory_port.sv
// Bench for data_memory_port: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
// A transaction-level model predicts the outputs of both every cycle.
`timescale 1ns/1ps

module tb_data_memory_port;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [2];
    logic        req_we [2];
    logic [31:0] req_address [2];
    logic [31:0] req_write_data [2];
    logic [3:0]  req_byte_en [2];
    logic        resp_ready [2];
    logic        req_ready [2];
    logic        resp_valid [2];
    logic [31:0] resp_read_data [2];
    logic        resp_error [2];

    int tests = 0;
    int fails = 0;

    data_memory_port #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid[0]),
        .req_ready      (req_ready[0]),
        .req_we         (req_we[0]),
        .req_address    (req_address[0]),
        .req_write_data (req_write_data[0]),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_byte_en    (req_byte_en[0]),
`endif
        .resp_valid     (resp_valid[0]),
        .resp_ready     (resp_ready[0]),
        .resp_read_data (resp_read_data[0]),
        .resp_error     (resp_error[0])
    );

    data_memory_port #(.DEPTH(64), .LATENCY(0)) u_dut_l0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid[1]),
        .req_ready      (req_ready[1]),
        .req_we         (req_we[1]),
        .req_address    (req_address[1]),
        .req_write_data (req_write_data[1]),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_byte_en    (req_byte_en[1]),
`endif
        .resp_valid     (resp_valid[1]),
        .resp_ready     (resp_ready[1]),
        .resp_read_data (resp_read_data[1]),
        .resp_error     (resp_error[1])
    );

    always #5 clock = ~clock;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction model: one pending request per instance, response due LATENCY edges
    // after acceptance, store lands in the model array on the commit edge.
    int          cyc = 0;
    bit          pend [2];
    int          acc [2];
    logic [31:0] exp_d [2];
    logic        exp_e [2];
    bit          pw [2];
    logic [31:0] pwd [2];
    logic [3:0]  pbe [2];
    int          pidx [2];
    logic [31:0] mm [2][64];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] = 1'b0;
                pw[i]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && cyc > acc[i] + lat_of(i) && resp_ready[i]) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && req_valid[i]) begin
                    logic err;
                    int   idx;
                    err     = (req_address[i] >= 32'd256) || (req_address[i] % 4 != 0);
                    idx     = int'(req_address[i] / 4) % 64;
                    pend[i] = 1'b1;
                    acc[i]  = cyc;
                    exp_e[i] = err;
                    if (req_we[i]) begin
                        exp_d[i] = 32'd0;
                        pw[i]    = !err;
                        pwd[i]   = req_write_data[i];
                        pidx[i]  = idx;
`ifdef DMEM_BYTE_ENABLE_EN
                        pbe[i]   = req_byte_en[i];
`else
                        pbe[i]   = 4'hF;
`endif
                    end else begin
                        pw[i]    = 1'b0;
                        exp_d[i] = err ? 32'd0 : mm[i][idx];
                    end
                end
                if (pend[i] && pw[i] && cyc == acc[i] + lat_of(i)) begin
                    for (int b = 0; b < 4; b++)
                        if (pbe[i][b]) mm[i][pidx[i]][8*b +: 8] = pwd[i][8*b +: 8];
                    pw[i] = 1'b0;
                end
            end
        end
    end

    // Compare every DUT output with the model once per cycle.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic rv;
            rv = pend[i] && (cyc >= acc[i] + lat_of(i));
            chk($sformatf("i%0d c%0d req_ready", i, cyc), 32'(req_ready[i]), 32'(!pend[i]));
            chk($sformatf("i%0d c%0d resp_valid", i, cyc), 32'(resp_valid[i]), 32'(rv));
            chk($sformatf("i%0d c%0d resp_read_data", i, cyc), resp_read_data[i],
                rv ? exp_d[i] : 32'd0);
            chk($sformatf("i%0d c%0d resp_error", i, cyc), 32'(resp_error[i]),
                32'(rv ? exp_e[i] : 1'b0));
        end
    end

    // One request/response; 'hold' keeps resp_ready low for that many cycles while a
    // competing request is offered.
    task automatic xact(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold, output logic [31:0] rd,
                        output logic re, output int acc_c, output int lat_m);
        int n;
        rd = 32'd0; re = 1'b0; acc_c = 0; lat_m = -1;
        n = 0;
        @(negedge clock);
        while (!req_ready[i] && n < 50) begin @(negedge clock); n++; end
        if (!req_ready[i]) begin
            chk($sformatf("i%0d timeout req_ready", i), 32'd0, 32'd1);
            return;
        end
        req_valid[i] = 1'b1; req_we[i] = we; req_address[i] = a;
        req_write_data[i] = d; req_byte_en[i] = be;
        @(posedge clock); #1;
        acc_c = cyc;
        req_valid[i] = 1'b0;
        n = 0;
        @(negedge clock);
        while (!resp_valid[i] && n < 50) begin @(negedge clock); n++; end
        if (!resp_valid[i]) begin
            chk($sformatf("i%0d timeout resp_valid", i), 32'd0, 32'd1);
            return;
        end
        lat_m = cyc - acc_c;
        rd = resp_read_data[i];
        re = resp_error[i];
        for (int h = 0; h < hold; h++) begin
            req_valid[i] = 1'b1; req_we[i] = 1'b1; req_write_data[i] = 32'hBAD;
            @(negedge clock);
            chk($sformatf("i%0d hold%0d resp_valid", i, h), 32'(resp_valid[i]), 32'd1);
            chk($sformatf("i%0d hold%0d data", i, h), resp_read_data[i], rd);
            chk($sformatf("i%0d hold%0d req_ready", i, h), 32'(req_ready[i]), 32'd0);
        end
        req_valid[i] = 1'b0;
        resp_ready[i] = 1'b1;
        @(posedge clock); #1;
        resp_ready[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        int          ac, ac2, lm;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_address[i] = 32'd0;
            req_write_data[i] = 32'd0; req_byte_en[i] = 4'hF; resp_ready[i] = 1'b0;
        end
        #3;
        chk("reset req_ready", 32'(req_ready[0]), 32'd1);
        chk("reset resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("reset data", resp_read_data[0], 32'd0);
        chk("reset error", 32'(resp_error[0]), 32'd0);
        #10 reset_n = 1'b1;

        // LATENCY=2 write then read.
        xact(0, 1'b1, 32'd8, 32'd777, 4'hF, 0, rd, re, ac, lm);
        chk("l2 store latency", 32'(lm), 32'd2);
        chk("l2 store data", rd, 32'd0);
        xact(0, 1'b0, 32'd8, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("l2 load data", rd, 32'd777);
        chk("l2 load err", 32'(re), 32'd0);
        chk("l2 load latency", 32'(lm), 32'd2);

        // LATENCY=0 stores and loads, back-to-back spacing.
        xact(1, 1'b1, 32'h0, 32'd5, 4'hF, 0, rd, re, ac, lm);
        xact(1, 1'b1, 32'h4, 32'd9, 4'hF, 0, rd, re, ac2, lm);
        chk("l0 store spacing", 32'(ac2 - ac), 32'd2);
        xact(1, 1'b0, 32'h0, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("l0 load0 data", rd, 32'd5);
        chk("l0 latency", 32'(lm), 32'd0);
        xact(1, 1'b0, 32'h4, 32'd0, 4'hF, 0, rd, re, ac2, lm);
        chk("l0 load4 data", rd, 32'd9);
        chk("l0 load spacing", 32'(ac2 - ac), 32'd2);

        // Backpressure with a competing request that must be ignored.
        xact(0, 1'b0, 32'd8, 32'd0, 4'hF, 3, rd, re, ac, lm);
        chk("bp data", rd, 32'd777);
        xact(0, 1'b0, 32'd8, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("bp no accept", rd, 32'd777);

        // Errors and address boundaries.
        xact(0, 1'b1, 32'h0, 32'h1234, 4'hF, 0, rd, re, ac, lm);
        xact(0, 1'b1, 32'h100, 32'hDEAD, 4'hF, 0, rd, re, ac, lm);
        chk("oob store err", 32'(re), 32'd1);
        xact(0, 1'b0, 32'h0, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("word0 intact", rd, 32'h1234);
        xact(0, 1'b0, 32'h9, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("misaligned err", 32'(re), 32'd1);
        chk("misaligned data", rd, 32'd0);
        xact(0, 1'b1, 32'hFC, 32'hCAFE, 4'hF, 0, rd, re, ac, lm);
        chk("last word store err", 32'(re), 32'd0);
        xact(0, 1'b0, 32'hFC, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("last word load", rd, 32'hCAFE);
        xact(1, 1'b0, 32'h102, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("l0 oob load err", 32'(re), 32'd1);

        // Reset during WAIT drops the store.
        xact(0, 1'b1, 32'd12, 32'd3, 4'hF, 0, rd, re, ac, lm);
        @(negedge clock);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_address[0] = 32'd12;
        req_write_data[0] = 32'hAAAA; req_byte_en[0] = 4'hF;
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        chk("in wait req_ready", 32'(req_ready[0]), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst req_ready", 32'(req_ready[0]), 32'd1);
        chk("async rst resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("async rst data", resp_read_data[0], 32'd0);
        chk("async rst error", 32'(resp_error[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        xact(0, 1'b0, 32'd12, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("dropped store", rd, 32'd3);

`ifdef DMEM_BYTE_ENABLE_EN
        xact(0, 1'b1, 32'd16, 32'h11223344, 4'hF, 0, rd, re, ac, lm);
        xact(0, 1'b1, 32'd16, 32'hAABBCCDD, 4'b0101, 0, rd, re, ac, lm);
        xact(0, 1'b0, 32'd16, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("byte lanes", rd, 32'h11BB33DD);
        xact(0, 1'b1, 32'd16, 32'hFFFFFFFF, 4'b0000, 0, rd, re, ac, lm);
        chk("be0 err", 32'(re), 32'd0);
        xact(0, 1'b0, 32'd16, 32'd0, 4'hF, 0, rd, re, ac, lm);
        chk("be0 no-op", rd, 32'h11BB33DD);
`endif

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

endmodule
